// File: rtl/dm_access_unit_pkg.sv
// Shared types for the data-memory access unit.
//   dm_size_e  : access size encoding on size_i (2'b11 behaves as a word)
//   dm_state_t : bus-transaction FSM states
//   is_misaligned() : alignment rule shared by the FSM and any future cache path
package dm_access_unit_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } dm_size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    REQ    = 2'b01,
    WAIT_R = 2'b10,
    DONE   = 2'b11
  } dm_state_t;

  // Bytes are never misaligned; halves need addr[0]=0; words (and the
  // reserved 2'b11 encoding) need addr[1:0]=0.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    case (size)
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = off[0];
      default: mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dm_load_formatter.sv
// Combinational load-data formatter: picks the addressed byte/half lane out
// of a 32-bit bus word and sign- or zero-extends it to 32 bits.
// Ports:
//   rdata_i    : raw 32-bit word from the data-memory bus
//   off_i      : byte offset within the word (addr[1:0])
//   size_i     : SZ_B / SZ_H / SZ_W (2'b11 treated as SZ_W)
//   sign_ext_i : 1 = replicate lane MSB, 0 = pad with zeros
//   data_o     : right-aligned, extended result
module dm_load_formatter
  import dm_access_unit_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        sign_ext_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (off_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (size_i)
      SZ_B:    data_o = {{24{sign_ext_i & byte_sel[7]}}, byte_sel};
      SZ_H:    data_o = {{16{sign_ext_i & half_sel[15]}}, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/dm_access_unit.sv
// Memory-stage data-memory access unit between EX/MEM and DM/WB.
// Converts a load/store into a req/gnt/rvalid bus transaction, formats store
// lanes and load data, and stalls the pipeline until the access retires.
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   valid_i .. alu_rslt_i         : EX/MEM instruction fields (held while stall_o=1)
//   mem_req_o .. mem_wdata_o      : data-memory bus request side
//   mem_gnt_i, mem_rvalid_i, mem_rdata_i : data-memory bus response side
//   stall_o                       : freeze upstream stages
//   misalign_o, bus_err_o         : one-cycle exception pulses
//   addr_o .. alu_rslt_o          : DM/WB register inputs
// Parameter TIMEOUT_CYC: cycles allowed in REQ+WAIT_R before bus_err_o (>= 2).
module dm_access_unit
  import dm_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wr_data_i,
  input  logic        dm_re_i,
  input  logic        dm_we_i,
  input  logic [1:0]  size_i,
  input  logic        sign_ext_i,
  input  logic [4:0]  rf_dst_addr_i,
  input  logic        rf_we_i,
  input  logic [31:0] alu_rslt_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic [31:0] addr_o,
  output logic [4:0]  rf_dst_addr_o,
  output logic        rf_we_o,
  output logic        dm_re_o,
  output logic [31:0] mem_data_o,
  output logic [31:0] alu_rslt_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  dm_state_t        state_q, state_d;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [31:0]      ld_data_q, ld_data_d;
  logic             err_q, err_d;

  logic        mem_op;
  logic        is_store;
  logic        misaligned;
  logic        timeout;
  logic [31:0] ld_fmt;

  assign mem_op     = valid_i & (dm_re_i | dm_we_i);
  // A request with both enables set is a store.
  assign is_store   = dm_we_i;
  assign misaligned = is_misaligned(size_i, addr_i[1:0]);
  assign timeout    = (tmo_cnt_q == CNT_W'(TIMEOUT_CYC));

  assign addr_o        = addr_i;
  assign rf_dst_addr_o = rf_dst_addr_i;
  assign dm_re_o       = dm_re_i;
  assign alu_rslt_o    = alu_rslt_i;

  dm_load_formatter u_ld_fmt (
    .rdata_i    (mem_rdata_i),
    .off_i      (addr_i[1:0]),
    .size_i     (size_i),
    .sign_ext_i (sign_ext_i),
    .data_o     (ld_fmt)
  );

  // Bus address/lanes come straight from the held EX/MEM fields, so they
  // stay stable for as long as upstream is stalled.
  always_comb begin
    mem_addr_o = {addr_i[31:2], 2'b00};
    case (size_i)
      SZ_B: begin
        mem_be_o    = 4'b0001 << addr_i[1:0];
        mem_wdata_o = {4{wr_data_i[7:0]}};
      end
      SZ_H: begin
        mem_be_o    = addr_i[1] ? 4'b1100 : 4'b0011;
        mem_wdata_o = {2{wr_data_i[15:0]}};
      end
      default: begin
        mem_be_o    = 4'b1111;
        mem_wdata_o = wr_data_i;
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    tmo_cnt_d  = '0;
    ld_data_d  = ld_data_q;
    err_d      = err_q;
    mem_req_o  = 1'b0;
    mem_we_o   = 1'b0;
    stall_o    = 1'b0;
    misalign_o = 1'b0;
    bus_err_o  = 1'b0;
    rf_we_o    = 1'b0;
    mem_data_o = '0;

    unique case (state_q)
      IDLE: begin
        if (!mem_op) begin
          rf_we_o = valid_i & rf_we_i;
        end else if (misaligned) begin
          // Retire immediately without touching the bus.
          misalign_o = 1'b1;
        end else begin
          stall_o = 1'b1;
          state_d = REQ;
        end
      end

      REQ: begin
        stall_o   = 1'b1;
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (timeout) begin
          // Abandon the access; request is withdrawn in this same cycle.
          bus_err_o = 1'b1;
          ld_data_d = '0;
          err_d     = 1'b1;
          state_d   = DONE;
        end else begin
          mem_req_o = 1'b1;
          mem_we_o  = is_store;
          if (mem_gnt_i) begin
            if (is_store) begin
              state_d = DONE;
            end else if (mem_rvalid_i) begin
              ld_data_d = ld_fmt;
              state_d   = DONE;
            end else begin
              state_d = WAIT_R;
            end
          end
        end
      end

      WAIT_R: begin
        stall_o   = 1'b1;
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (timeout) begin
          bus_err_o = 1'b1;
          ld_data_d = '0;
          err_d     = 1'b1;
          state_d   = DONE;
        end else if (mem_rvalid_i) begin
          ld_data_d = ld_fmt;
          state_d   = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
        err_d   = 1'b0;
        if (!is_store && !err_q) begin
          mem_data_o = ld_data_q;
          rf_we_o    = valid_i & rf_we_i;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tmo_cnt_q <= '0;
      ld_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_cnt_q <= tmo_cnt_d;
      ld_data_q <= ld_data_d;
      err_q     <= err_d;
    end
  end

endmodule
